// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame writer and the display reader:
// default geometry, framebuffer address width and the writer state encoding.
package lcd_pkg;

  localparam int H_PIXELS_DEF = 160;
  localparam int V_LINES_DEF  = 144;
  localparam int FB_ADDR_W    = 15;

  typedef enum logic [1:0] {
    ST_OFF         = 2'd0,
    ST_LINE        = 2'd1,
    ST_WAIT_HBLANK = 2'd2,
    ST_WAIT_VBLANK = 2'd3
  } wr_state_e;

endpackage

// File: rtl/lcd_fb_addr_gen.sv
// Framebuffer position tracker: owns x, y and an incrementally maintained
// row_base so the write address never needs a multiplier.
module lcd_fb_addr_gen
  import lcd_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_in,
  input  logic                 step_in,
  input  logic                 next_line_in,
  output logic [FB_ADDR_W-1:0] addr_out,
  output logic                 x_zero_out,
  output logic                 line_full_out,
  output logic                 frame_full_out
);

  localparam int X_W = $clog2(H_PIXELS);
  localparam int Y_W = $clog2(V_LINES + 1);

  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [FB_ADDR_W-1:0] row_base_q, row_base_d;

  assign addr_out       = row_base_q + FB_ADDR_W'(x_q);
  assign x_zero_out     = (x_q == X_W'(0));
  assign line_full_out  = (x_q == X_W'(H_PIXELS - 1));
  assign frame_full_out = (y_q == Y_W'(V_LINES - 1));

  // Clear wins; a completed or cut-short line advances y exactly once.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    if (clear_in) begin
      x_d        = X_W'(0);
      y_d        = Y_W'(0);
      row_base_d = FB_ADDR_W'(0);
    end else if (next_line_in || (step_in && line_full_out)) begin
      x_d        = X_W'(0);
      y_d        = y_q + Y_W'(1);
      row_base_d = row_base_q + FB_ADDR_W'(H_PIXELS);
    end else if (step_in) begin
      x_d = x_q + X_W'(1);
    end else begin
      x_d = x_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q        <= X_W'(0);
      y_q        <= Y_W'(0);
      row_base_q <= FB_ADDR_W'(0);
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// Writes PPU pixels into a banked framebuffer and swaps banks per frame.
// LCD_FRAME_WRITER_DOUBLE_BUFFER_EN builds the bank toggle; otherwise bank is 0.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [1:0]           pixel_in,
  input  logic                 pixel_valid_in,
  input  logic                 hblank_in,
  input  logic                 vblank_in,
  input  logic                 lcd_en_in,
  output logic [FB_ADDR_W-1:0] fb_addr_out,
  output logic [1:0]           fb_data_out,
  output logic                 fb_we_out,
  output logic                 fb_bank_out,
  output logic                 frame_done_out,
  output logic                 frame_err_out
);

  wr_state_e            state_q, state_d;
  logic                 hblank_q, hblank_d, vblank_q, vblank_d;
  logic                 we_q, we_d, done_q, done_d, err_q, err_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]           data_q, data_d;
  logic                 clear_s, step_s, next_line_s;
  logic [FB_ADDR_W-1:0] gen_addr_s;
  logic                 x_zero_s, line_full_s, frame_full_s;
  logic                 hb_rise_s, hb_fall_s, vb_rise_s, line_done_s, short_line_s;

  lcd_fb_addr_gen #(.H_PIXELS(H_PIXELS), .V_LINES(V_LINES)) u_addr_gen (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (clear_s),
    .step_in       (step_s),
    .next_line_in  (next_line_s),
    .addr_out      (gen_addr_s),
    .x_zero_out    (x_zero_s),
    .line_full_out (line_full_s),
    .frame_full_out(frame_full_s)
  );

  assign hblank_d    = hblank_in;
  assign vblank_d    = vblank_in;
  assign hb_rise_s   = hblank_in & ~hblank_q;
  assign hb_fall_s   = ~hblank_in & hblank_q;
  assign vb_rise_s   = vblank_in & ~vblank_q;
  assign line_done_s = pixel_valid_in & line_full_s;
  // Short line is judged on x after this cycle's pixel has been counted.
  assign short_line_s = hb_rise_s & (pixel_valid_in ? ~line_full_s : ~x_zero_s);

  // Writer state machine and registered framebuffer port.
  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = err_q;
    clear_s     = 1'b0;
    step_s      = 1'b0;
    next_line_s = 1'b0;
    if (!lcd_en_in) begin
      state_d = ST_OFF;
      err_d   = 1'b0;
      clear_s = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_LINE;
          clear_s = 1'b1;
        end
        ST_LINE: begin
          if (vb_rise_s) begin
            err_d   = 1'b1;
            clear_s = 1'b1;
          end else begin
            if (pixel_valid_in) begin
              we_d   = 1'b1;
              addr_d = gen_addr_s;
              data_d = pixel_in;
              step_s = 1'b1;
            end else begin
              step_s = 1'b0;
            end
            if (line_done_s || short_line_s) begin
              next_line_s = short_line_s;
              err_d       = err_q | short_line_s;
              state_d     = frame_full_s ? ST_WAIT_VBLANK : ST_WAIT_HBLANK;
            end else begin
              state_d = ST_LINE;
            end
          end
        end
        ST_WAIT_HBLANK: begin
          if (vb_rise_s) begin
            err_d   = 1'b1;
            clear_s = 1'b1;
            state_d = ST_LINE;
          end else if (hb_fall_s) begin
            err_d   = err_q | pixel_valid_in;
            state_d = ST_LINE;
          end else begin
            err_d = err_q | pixel_valid_in;
          end
        end
        ST_WAIT_VBLANK: begin
          if (vb_rise_s) begin
            done_d  = 1'b1;
            clear_s = 1'b1;
            state_d = ST_LINE;
          end else begin
            err_d = err_q | pixel_valid_in;
          end
        end
        default: begin
          state_d = ST_OFF;
          clear_s = 1'b1;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_OFF;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= FB_ADDR_W'(0);
      data_q   <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef LCD_FRAME_WRITER_DOUBLE_BUFFER_EN
  logic bank_q, bank_d;

  assign bank_d = done_d ? ~bank_q : bank_q;

  // Bank flips together with the frame-done pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign fb_bank_out = bank_q;
`else
  assign fb_bank_out = 1'b0;
`endif

  assign fb_we_out      = we_q;
  assign fb_addr_out    = addr_q;
  assign fb_data_out    = data_q;
  assign frame_done_out = done_q;
  assign frame_err_out  = err_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed-sequence bench for lcd_frame_writer with random pixel data; expected
// writes come from line/column arithmetic, never from the DUT.
module tb_lcd_frame_writer;

  localparam int H = 160;
  localparam int V = 144;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  pixel_in = 2'b00;
  logic        pixel_valid_in = 1'b0;
  logic        hblank_in = 1'b0;
  logic        vblank_in = 1'b0;
  logic        lcd_en_in = 1'b1;
  logic [14:0] fb_addr_out;
  logic [1:0]  fb_data_out;
  logic        fb_we_out, fb_bank_out, frame_done_out, frame_err_out;

  lcd_frame_writer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .pixel_in      (pixel_in),
    .pixel_valid_in(pixel_valid_in),
    .hblank_in     (hblank_in),
    .vblank_in     (vblank_in),
    .lcd_en_in     (lcd_en_in),
    .fb_addr_out   (fb_addr_out),
    .fb_data_out   (fb_data_out),
    .fb_we_out     (fb_we_out),
    .fb_bank_out   (fb_bank_out),
    .frame_done_out(frame_done_out),
    .frame_err_out (frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;
  int done_seen = 0;

  logic        chk_on = 1'b0;
  logic        pend_we = 1'b0, pend_done = 1'b0, pend_rst = 1'b0;
  logic        pend_err_en = 1'b0, pend_err = 1'b0;
  logic [14:0] pend_addr = 15'd0;
  logic [1:0]  pend_data = 2'b00;
  logic        exp_bank = 1'b0;
  logic        rst_v = 1'b1;
  logic        en_v = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_err(input logic e);
    pend_err_en = 1'b1;
    pend_err    = e;
  endtask

  // One clock: check what the previous cycle should have produced, then drive.
  task automatic cyc(input logic v, input logic [1:0] p, input logic hb, input logic vb,
                     input logic e_we, input logic [14:0] e_addr, input logic e_done);
    @(negedge clk_in);
    if (chk_on) begin
      if (pend_rst) exp_bank = 1'b0;
`ifdef LCD_FRAME_WRITER_DOUBLE_BUFFER_EN
      if (pend_done) exp_bank = ~exp_bank;
`endif
      if (fb_we_out === 1'b1) writes_seen++;
      if (frame_done_out === 1'b1) done_seen++;
      check("we", fb_we_out, pend_we);
      check("frame_done", frame_done_out, pend_done);
      check("bank", fb_bank_out, exp_bank);
      if (pend_we) begin
        check("addr", fb_addr_out, pend_addr);
        check("data", fb_data_out, pend_data);
      end
      if (pend_rst) begin
        check("rst_addr", fb_addr_out, 32'd0);
        check("rst_data", fb_data_out, 32'd0);
      end
      if (pend_err_en) check("frame_err", frame_err_out, pend_err);
    end
    pend_err_en    = 1'b0;
    rst_in         = rst_v;
    lcd_en_in      = en_v;
    pixel_valid_in = v;
    pixel_in       = p;
    hblank_in      = hb;
    vblank_in      = vb;
    pend_we        = e_we & ~rst_v;
    pend_addr      = e_addr;
    pend_data      = p;
    pend_done      = e_done & ~rst_v;
    pend_rst       = rst_v;
    chk_on         = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
  endtask

  // Pixels c0..c1-1 of line ln land at ln*H+c; optional hblank pulse afterwards.
  task automatic send_line(input int ln, input int c0, input int c1, input bit hb_after, input bit gaps);
    for (int c = c0; c < c1; c++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
      cyc(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b1, 15'(ln * H + c), 1'b0);
    end
    if (hb_after) begin
      cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
    end
  endtask

  task automatic vblank_pulse(input logic e_done);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 15'd0, e_done);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
  endtask

  initial begin
    // Reset held with the display enabled.
    rst_v = 1'b1;
    en_v  = 1'b1;
    idle(3);
    expect_err(1'b0);
    rst_v = 1'b0;
    idle(1);

    // Full frame; pixel 3 of line 0 carries a known shade.
    writes_seen = 0;
    done_seen   = 0;
    send_line(0, 0, 3, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 15'd3, 1'b0);
    send_line(0, 4, H, 1'b1, 1'b0);
    for (int l = 1; l < V; l++) send_line(l, 0, H, 1'b1, 1'b0);
    vblank_pulse(1'b1);
    expect_err(1'b0);
    idle(1);
    check("frame1_writes", writes_seen, 32'(H * V));
    check("frame1_done_count", done_seen, 32'd1);

    // Short frame: vblank after 100 lines, then a full frame from address 0.
    for (int l = 0; l < 100; l++) send_line(l, 0, H, 1'b1, 1'b0);
    vblank_pulse(1'b0);
    expect_err(1'b1);
    idle(1);
    check("short_frame_no_done", done_seen, 32'd1);
    for (int l = 0; l < V; l++) send_line(l, 0, H, 1'b1, 1'b0);
    vblank_pulse(1'b1);
    expect_err(1'b1);
    idle(1);
    check("two_frames_done_count", done_seen, 32'd2);

    // Display off clears the sticky error.
    en_v = 1'b0;
    idle(2);
    expect_err(1'b0);
    en_v = 1'b1;
    idle(1);

    // 161st pixel before hblank is dropped and flagged.
    send_line(0, 0, H, 1'b0, 1'b1);
    cyc(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
    expect_err(1'b1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 15'd0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
    send_line(1, 0, 4, 1'b0, 1'b1);

    // Display off mid-frame at line 50, then back on.
    en_v = 1'b0;
    idle(1);
    en_v = 1'b1;
    idle(1);
    for (int l = 0; l < 50; l++) send_line(l, 0, H, 1'b1, 1'b1);
    send_line(50, 0, 20, 1'b0, 1'b1);
    en_v = 1'b0;
    writes_seen = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
    expect_err(1'b0);
    en_v = 1'b1;
    idle(1);
    check("writes_while_off", writes_seen, 32'd1);
    send_line(0, 0, 8, 1'b0, 1'b1);
    expect_err(1'b0);

    // Pixel together with hblank rise mid-line: written, then short-line error.
    send_line(0, 8, 18, 1'b0, 1'b0);
    cyc(1'b1, 2'($urandom), 1'b1, 1'b0, 1'b1, 15'd18, 1'b0);
    expect_err(1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);
    send_line(1, 0, 5, 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
